// File: rtl/rblwe_ct_loader.sv
// Ciphertext loader for the RBLWE decryptor: buffers one 136-word ciphertext from a
// valid/ready stream, replays it as 256 parallel load cycles, pulses start, then tracks dec_valid.
module rblwe_ct_loader #(
    parameter int GAP_CYCLES = 3,
    parameter int START_LEN  = 1,
    parameter int TIMEOUT    = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  c1_out,
    output logic [7:0]  c2_out,
    output logic        r2_out,
    output logic        load,
    output logic        start,
    input  logic        dec_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        proto_err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] STREAM = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [31:0]   c1_mem [64];
    logic [31:0]   c2_mem [64];
    logic [255:0]  r2_reg;

    logic          full;
    logic          full_clr;
    logic [7:0]    wcnt;
    logic          accept;

    logic [2:0]    state, state_n;
    logic [7:0]    scnt, scnt_n;
    logic [15:0]   pcnt, pcnt_n;
    logic [8:0]    dcnt, dcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          load_n, start_n, done_n, to_n, pe_n;

    logic [7:0]    rd_idx;
    logic [31:0]   c1_word, c2_word;
    logic [7:0]    c1_byte, c2_byte;
    logic          r2_bit;

    assign s_ready = !full && !reset;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            wcnt <= '0;
        end else begin
            if (full_clr)
                full <= 1'b0;
            if (accept) begin
                if (wcnt == 8'd135) begin
                    full <= 1'b1;
                    wcnt <= '0;
                end else begin
                    wcnt <= wcnt + 8'd1;
                end
            end
        end
    end

    // Buffer contents need no reset: a fresh fill always rewrites every word before streaming.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wcnt < 8'd64)
                c1_mem[wcnt[5:0]] <= s_data;
            else if (wcnt < 8'd128)
                c2_mem[wcnt[5:0]] <= s_data;
            else
                r2_reg[{wcnt[2:0], 5'd0} +: 32] <= s_data;
        end
    end

    // Outputs are registered, so the buffer is read one coefficient ahead of the stream counter.
    assign rd_idx  = (state == STREAM) ? scnt + 8'd1 : 8'd0;
    assign c1_word = c1_mem[rd_idx[7:2]];
    assign c2_word = c2_mem[rd_idx[7:2]];
    assign c1_byte = c1_word[{rd_idx[1:0], 3'd0} +: 8];
    assign c2_byte = c2_word[{rd_idx[1:0], 3'd0} +: 8];
    assign r2_bit  = r2_reg[rd_idx];

    always_comb begin
        state_n  = state;
        scnt_n   = scnt;
        pcnt_n   = pcnt;
        dcnt_n   = dcnt;
        tcnt_n   = tcnt;
        load_n   = 1'b0;
        start_n  = 1'b0;
        done_n   = 1'b0;
        full_clr = 1'b0;
        to_n     = timeout_err;
        pe_n     = proto_err | (dec_valid && (state != WAIT));
        case (state)
            IDLE: begin
                if (full) begin
                    state_n = STREAM;
                    scnt_n  = '0;
                    load_n  = 1'b1;
                end
            end
            STREAM: begin
                if (scnt == 8'd255) begin
                    full_clr = 1'b1;
                    pcnt_n   = '0;
                    if (GAP_CYCLES == 0) begin
                        state_n = START;
                        start_n = 1'b1;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    scnt_n = scnt + 8'd1;
                    load_n = 1'b1;
                end
            end
            GAP: begin
                if (pcnt == 16'(GAP_CYCLES - 1)) begin
                    state_n = START;
                    pcnt_n  = '0;
                    start_n = 1'b1;
                end else begin
                    pcnt_n = pcnt + 16'd1;
                end
            end
            START: begin
                if (pcnt == 16'(START_LEN - 1)) begin
                    state_n = WAIT;
                    dcnt_n  = '0;
                    tcnt_n  = '0;
                end else begin
                    pcnt_n  = pcnt + 16'd1;
                    start_n = 1'b1;
                end
            end
            WAIT: begin
                tcnt_n = tcnt + 1'b1;
                if (dec_valid)
                    dcnt_n = dcnt + 9'd1;
                if (dec_valid && dcnt == 9'd255) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            scnt        <= '0;
            pcnt        <= '0;
            dcnt        <= '0;
            tcnt        <= '0;
            load        <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            c1_out      <= '0;
            c2_out      <= '0;
            r2_out      <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_n;
            scnt        <= scnt_n;
            pcnt        <= pcnt_n;
            dcnt        <= dcnt_n;
            tcnt        <= tcnt_n;
            load        <= load_n;
            start       <= start_n;
            done        <= done_n;
            busy        <= (state_n != IDLE);
            c1_out      <= load_n ? c1_byte : '0;
            c2_out      <= load_n ? c2_byte : '0;
            r2_out      <= load_n & r2_bit;
            timeout_err <= to_n;
            proto_err   <= pe_n;
        end
    end
endmodule
